// File: rtl/mac_sched.sv
// Two-channel multiply-accumulate scheduler: round-robin issue into a LAT-deep
// multiply pipeline, with per-channel accumulators and a shared result register.
module mac_sched #(
    parameter int DW  = 32,
    parameter int AW  = 80,
    parameter int LAT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [1:0]    req_last,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] b0,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] b1,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_ch,
    output logic [AW-1:0] res_data,
    output logic [1:0]    busy
);

    localparam int PW = 2 * DW;

    typedef struct packed {
        logic          ch;
        logic          last;
        logic [PW-1:0] prod;
    } op_t;

    logic [LAT-1:0] pipe_vld;
    op_t            pipe_op [LAT];
    logic [AW-1:0]  acc [2];
    logic           res_vld_q;
    logic           res_ch_q;
    logic [AW-1:0]  res_data_q;
    logic           ptr;

    logic [1:0]     inflight;
    logic [1:0]     last_inflight;
    logic [1:0]     pending;
    logic [1:0]     elig;
    logic [1:0]     grant;
    logic           issue;
    logic           issue_ch;
    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_b;
    op_t            issue_op;
    op_t            tail;
    logic [AW-1:0]  sum;

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        inflight      = '0;
        last_inflight = '0;
        pending       = '0;
        elig          = '0;
        grant         = '0;
        for (int i = 0; i < LAT; i++) begin
            if (pipe_vld[i]) begin
                inflight[pipe_op[i].ch] = 1'b1;
                if (pipe_op[i].last) last_inflight[pipe_op[i].ch] = 1'b1;
            end
        end
        if (res_vld_q) pending[res_ch_q] = 1'b1;
        // A closing op needs the result register free and no other closing op ahead of it.
        for (int k = 0; k < 2; k++) begin
            elig[k] = req_valid[k] & ~last_inflight[k] & ~pending[k]
                    & (~req_last[k] | ~(res_vld_q | (|last_inflight)));
        end
        if (!reset) begin
            if (elig[ptr])       grant[ptr]  = 1'b1;
            else if (elig[!ptr]) grant[!ptr] = 1'b1;
        end
    end

    assign issue    = |grant;
    assign issue_ch = grant[1];
    assign op_a     = issue_ch ? a1 : a0;
    assign op_b     = issue_ch ? b1 : b0;
    assign issue_op = '{ch: issue_ch, last: req_last[issue_ch], prod: PW'(op_a) * PW'(op_b)};
    assign tail     = pipe_op[LAT-1];
    assign sum      = acc[tail.ch] + AW'(tail.prod);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld   <= '0;
            acc[0]     <= '0;
            acc[1]     <= '0;
            res_vld_q  <= 1'b0;
            res_ch_q   <= 1'b0;
            res_data_q <= '0;
            ptr        <= 1'b0;
        end else begin
            pipe_vld[0] <= issue;
            for (int i = 1; i < LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
            if (issue) ptr <= ~issue_ch;
            if (res_vld_q && res_ready) res_vld_q <= 1'b0;
            // A closing op may load the result in the same cycle the old one is consumed.
            if (pipe_vld[LAT-1]) begin
                if (tail.last) begin
                    res_data_q   <= sum;
                    res_ch_q     <= tail.ch;
                    res_vld_q    <= 1'b1;
                    acc[tail.ch] <= '0;
                end else begin
                    acc[tail.ch] <= sum;
                end
            end
        end
    end

    // NOTE: the payload array carries no reset; pipe_vld alone decides whether a stage is live.
    always_ff @(posedge clk) begin
        pipe_op[0] <= issue_op;
        for (int i = 1; i < LAT; i++) pipe_op[i] <= pipe_op[i-1];
    end

    assign req_ready = grant;
    assign busy      = reset ? 2'b00 : (inflight | pending);
    assign res_valid = res_vld_q & ~reset;
    assign res_ch    = res_ch_q & ~reset;
    assign res_data  = reset ? '0 : res_data_q;

endmodule

// File: doc/mac_sched.md
MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 Parameter DW, default 32, operand width in bits (unsigned).
REQ-002 Parameter AW, default 80, accumulator/result width in bits; AW >= 2*DW.
REQ-003 Parameter LAT, default 3, multiply pipeline depth in cycles; LAT >= 1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  2  per-channel operand-pair valid; bit k = channel k.
REQ-007 req_ready  output  2  per-channel accept; at most one bit high per cycle.
REQ-008 req_last  input  2  per-channel flag: this pair closes the current dot product.
REQ-009 a0, b0  input  DW each  channel 0 operands.
REQ-010 a1, b1  input  DW each  channel 1 operands.
REQ-011 res_valid  output  1  result register holds an unconsumed result.
REQ-012 res_ready  input  1  downstream accepts the result.
REQ-013 res_ch  output  1  channel that owns res_data.
REQ-014 res_data  output  AW  completed dot-product sum.
REQ-015 busy  output  2  bit k high while any channel-k op is in flight or its result is unconsumed.

Function
REQ-016 Issue occurs on a cycle where req_valid[k] & req_ready[k]; at most one issue per cycle.
REQ-017 Channel k is eligible when req_valid[k]=1, no channel-k last op is in flight, and no channel-k result is pending.
REQ-018 An op with req_last=1 is eligible only if res_valid=0 and no last op of either channel is in flight.
REQ-019 Arbitration is round-robin: priority pointer resets to channel 0; if both channels are eligible, the pointer channel wins; after any issue the pointer moves to the non-issued channel.
REQ-020 req_ready[k] = grant to channel k; it may depend combinationally on req_valid, req_last and state, never on res_ready.
REQ-021 Each issue enters a LAT-stage pipeline carrying {channel, last, a*b}; the product is full 2*DW bits, zero-extended to AW.
REQ-022 The product reaches the accumulate stage exactly LAT cycles after issue; acc[ch] <= acc[ch] + product, wrapping modulo 2^AW.
REQ-023 If the op is last: res_data <= acc[ch] + product, res_ch <= ch, res_valid <= 1, and acc[ch] <= 0 in the same cycle.
REQ-024 res_valid rises LAT+1 cycles after the last op's issue edge.
REQ-025 res_valid, res_ch and res_data hold stable until the res_valid & res_ready edge, then res_valid clears; a new result may load in the same cycle it clears.
REQ-026 A single op with req_last=1 yields res_data = a*b.
REQ-027 The two channels' accumulators are independent; interleaved issues never mix sums.
REQ-028 busy[k] rises the cycle after a channel-k issue and falls the cycle after the channel-k result is consumed, or after the last channel-k non-last op drains when no last op is pending.

Reset
REQ-029 While reset=1: res_valid=0, req_ready=0, busy=0, res_ch=0, res_data=0, both accumulators=0, all pipeline valid bits=0, pointer=channel 0.
REQ-030 Reset mid-operation discards all in-flight ops and partial sums; no result for them is ever emitted.
REQ-031 The first issue is possible in the first cycle after reset deasserts.

Verification
REQ-032 Ch0 sends (3,4),(5,6,last), res_ready=1 -> one result: res_ch=0, res_data=42, LAT+1 cycles after the second issue.
REQ-033 Both channels valid every cycle, ch0 pairs (1,1), ch1 pairs (2,2), 4 ops each, 4th last -> grants alternate 0,1,0,1,...; results ch0=4, ch1=16, in issue order of their last ops.
REQ-034 Ch1 last completes with res_ready=0 for 10 cycles -> res_valid/res_data stay stable; ch1 and any last op held off (req_ready=0); ch0 non-last ops still issue.
REQ-035 DW=32: (0xFFFFFFFF, 0xFFFFFFFF) twice, second last -> res_data = 0x1_FFFFFFFC_00000002.
REQ-036 Reset asserted 1 cycle after a ch0 last issue -> no res_valid afterwards; a following ch0 (7,7,last) yields res_data=49.
REQ-037 Ch0 and ch1 both present last ops in the same cycle -> only the pointer channel is granted; the other waits until that result is consumed.
